mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
Round-robin arbiter that shares one shift-add multiplier (START/DONE handshake, DONE high while the multiplier is idle) among N_REQ requesters. It selects a requester, latches its operands, pulses START, tracks DONE falling then rising, captures the product and returns it with a one-cycle acknowledge. It sits between the requesting blocks and the multiplier's controller/datapath pair.

Parameters:
N_REQ, 4, number of requesters (2..8)
W, 4, operand width; product width is 2*W
BUSY_TIMEOUT, 4, max cycles in WAIT_BUSY for DONE to fall before error

Ports:
i_CLK  input  1  clock, all logic on rising edge
i_RESET  input  1  synchronous active-low reset
i_REQ  input  N_REQ  per-requester request level
i_A  input  N_REQ*W  packed multiplicands, requester k at bits [k*W +: W]
i_B  input  N_REQ*W  packed multipliers, same packing
o_ACK  output  N_REQ  one-hot, one-cycle completion pulse
o_RESULT  output  2*W  product, valid when any o_ACK bit is high
o_ERR  output  1  sticky: multiplier failed to leave idle after START
o_BUSY  output  1  high in every state except IDLE
o_GNT_ID  output  3  index of current/last granted requester
o_MUL_START  output  1  multiplier start
o_MUL_A  output  W  registered operand A to multiplier
o_MUL_B  output  W  registered operand B (operand whose bits drive the multiplier's LSB test)
i_MUL_DONE  input  1  multiplier DONE (high when idle)
i_MUL_PRODUCT  input  2*W  multiplier product

Behaviour:
- Reset (i_RESET low at rising edge, any state): state IDLE; o_ACK, o_RESULT, o_MUL_START, o_MUL_A, o_MUL_B, o_BUSY, o_GNT_ID, o_ERR, timeout counter all 0; RR pointer 0. Abort mid-operation silently, no ACK.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESPOND.
- IDLE: if any i_REQ bit set and i_MUL_DONE=1, grant first set bit searching from pointer upward with wrap; latch its A/B into o_MUL_A/o_MUL_B, set o_GNT_ID -> LAUNCH. If i_MUL_DONE=0, wait in IDLE.
- LAUNCH: o_MUL_START=1 for exactly this cycle; clear timeout counter -> WAIT_BUSY.
- WAIT_BUSY: i_MUL_DONE=0 -> WAIT_DONE. Otherwise increment counter. On reaching BUSY_TIMEOUT, set o_ERR, pulse o_ACK for the grantee with o_RESULT=0 -> RESPOND-equivalent exit to IDLE.
- WAIT_DONE: i_MUL_DONE=1 -> capture i_MUL_PRODUCT into o_RESULT -> RESPOND.
- RESPOND: o_ACK[grant]=1 for one cycle, o_RESULT held. Pointer = (grant+1) mod N_REQ -> IDLE.
- o_RESULT holds its last value until the next capture. o_MUL_A/o_MUL_B hold until the next grant.
- Operands are sampled only at grant. Requester must hold i_REQ until ACK. Dropping i_REQ after grant does not cancel; ACK still issued.
- A requester whose i_REQ is still high in the IDLE cycle after its ACK is a new request, subject to round-robin.
- Latency with the 4-bit shift-add multiplier: grant cycle = 0, ACK at cycle 12 + popcount(B). Minimum back-to-back grant spacing 13 cycles.
- Simultaneous requests: the pointer guarantees each active requester is served within N_REQ grants.
- o_ERR clears only on reset.

Test Plan:
- Single request: reset, then req0 with A=4'd5, B=4'd3 -> one START pulse, o_ACK=4'b0001 at cycle 14 after grant, o_RESULT=8'd15, o_GNT_ID=0.
- B=0 and A=B=15: (A=9, B=0) -> ACK at cycle 12, result 0. (A=15, B=15) -> ACK at cycle 16, result 225.
- Round-robin: all four i_REQ held high, distinct operands -> grants in order 0,1,2,3,0. Each ACK is one-hot and one cycle long, and each result is correct.
- Pointer wrap and fairness: req3 served, then req0 and req3 both high -> req0 granted next.
- Timeout: stub multiplier holds DONE=1 permanently -> after BUSY_TIMEOUT cycles, o_ERR=1, ACK with result 0, return to IDLE, o_ERR stays 1.
- Reset mid-operation: assert i_RESET low during WAIT_DONE -> next edge all outputs 0, no ACK. After release, a new req2 completes normally.

Source files
------------

// File: rtl/mult_share_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module   : mult_share_arbiter
//  Purpose  : Round-robin arbiter that lends a single shift-add multiplier
//             to N_REQ requesters. It picks a requester, latches its
//             operands, pulses START, follows DONE falling and then rising,
//             captures the product and returns it with a one-cycle ACK.
//
//  Ports    : i_CLK          clock, rising edge
//             i_RESET        synchronous reset, active low
//             i_REQ          per-requester request level
//             i_A / i_B      packed operands, requester k at [k*W +: W]
//             o_ACK          one-hot, one-cycle completion pulse
//             o_RESULT       product, valid while any o_ACK bit is high
//             o_ERR          sticky: multiplier never left idle after START
//             o_BUSY         high in every state except IDLE
//             o_GNT_ID       index of the current / last granted requester
//             o_MUL_START    one-cycle start pulse to the multiplier
//             o_MUL_A/B      registered operands to the multiplier
//             i_MUL_DONE     multiplier DONE (high while idle)
//             i_MUL_PRODUCT  multiplier product
//
//  Revision : 1.0  initial release
//------------------------------------------------------------------------------
module mult_share_arbiter #(
   parameter int N_REQ        = 4,
   parameter int W            = 4,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic               i_CLK,
   input  logic               i_RESET,
   input  logic [N_REQ-1:0]   i_REQ,
   input  logic [N_REQ*W-1:0] i_A,
   input  logic [N_REQ*W-1:0] i_B,
   output logic [N_REQ-1:0]   o_ACK,
   output logic [2*W-1:0]     o_RESULT,
   output logic               o_ERR,
   output logic               o_BUSY,
   output logic [2:0]         o_GNT_ID,
   output logic               o_MUL_START,
   output logic [W-1:0]       o_MUL_A,
   output logic [W-1:0]       o_MUL_B,
   input  logic               i_MUL_DONE,
   input  logic [2*W-1:0]     i_MUL_PRODUCT
);

   // Counter only has to reach BUSY_TIMEOUT-1; the timeout fires on the
   // cycle that would have incremented it to BUSY_TIMEOUT.
   localparam int               c_CNT_W    = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BUSY_TIMEOUT - 1);
   localparam logic [2:0]       c_LAST_REQ = 3'(N_REQ - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LAUNCH    = 3'd1,
      S_WAIT_BUSY = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_RESPOND   = 3'd4
   } state_t;

   state_t               r_state;
   logic [2:0]           r_ptr;
   logic [2:0]           r_gnt;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [N_REQ-1:0]     r_ack;
   logic [2*W-1:0]       r_result;
   logic                 r_err;
   logic                 r_busy;
   logic                 r_start;
   logic [W-1:0]         r_mul_a;
   logic [W-1:0]         r_mul_b;

   logic                 w_any_req;
   logic                 w_hi_found;
   logic [2:0]           w_hi;
   logic [2:0]           w_lo;
   logic [2:0]           w_sel;
   logic [W-1:0]         w_sel_a;
   logic [W-1:0]         w_sel_b;
   logic [N_REQ-1:0]     w_gnt_onehot;

   assign w_any_req = |i_REQ;

   // Round-robin pick: the lowest requester at or above the pointer wins;
   // if none exists there, wrap and take the lowest requester overall.
   always_comb begin
      w_hi       = '0;
      w_lo       = '0;
      w_hi_found = 1'b0;
      for (int j = N_REQ - 1; j >= 0; j--) begin
         if (i_REQ[j]) begin
            w_lo = 3'(j);
            if (3'(j) >= r_ptr) begin
               w_hi       = 3'(j);
               w_hi_found = 1'b1;
            end
         end
      end
      w_sel = w_hi_found ? w_hi : w_lo;
   end

   // Operand mux for the selected requester and one-hot ACK for the grantee.
   always_comb begin
      w_sel_a      = '0;
      w_sel_b      = '0;
      w_gnt_onehot = '0;
      for (int j = 0; j < N_REQ; j++) begin
         if (w_sel == 3'(j)) begin
            w_sel_a = i_A[j*W +: W];
            w_sel_b = i_B[j*W +: W];
         end
         w_gnt_onehot[j] = (r_gnt == 3'(j));
      end
   end

   always_ff @(posedge i_CLK) begin
      if (!i_RESET) begin
         r_state  <= S_IDLE;
         r_ptr    <= '0;
         r_gnt    <= '0;
         r_cnt    <= '0;
         r_ack    <= '0;
         r_result <= '0;
         r_err    <= 1'b0;
         r_busy   <= 1'b0;
         r_start  <= 1'b0;
         r_mul_a  <= '0;
         r_mul_b  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // A grant is only issued while the multiplier reports idle.
               if (w_any_req && i_MUL_DONE) begin
                  r_gnt   <= w_sel;
                  r_mul_a <= w_sel_a;
                  r_mul_b <= w_sel_b;
                  r_start <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               r_start <= 1'b0;
               r_cnt   <= '0;
               r_state <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               if (!i_MUL_DONE) begin
                  r_state <= S_WAIT_DONE;
               end else if (r_cnt == c_CNT_LAST) begin
                  // Multiplier ignored START: flag it and release the
                  // requester with a zero result so it does not stall.
                  r_err    <= 1'b1;
                  r_result <= '0;
                  r_ack    <= w_gnt_onehot;
                  r_state  <= S_RESPOND;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_WAIT_DONE: begin
               if (i_MUL_DONE) begin
                  r_result <= i_MUL_PRODUCT;
                  r_ack    <= w_gnt_onehot;
                  r_state  <= S_RESPOND;
               end
            end
            S_RESPOND: begin
               r_ack   <= '0;
               r_busy  <= 1'b0;
               r_ptr   <= (r_gnt == c_LAST_REQ) ? 3'd0 : r_gnt + 3'd1;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_ACK       = r_ack;
   assign o_RESULT    = r_result;
   assign o_ERR       = r_err;
   assign o_BUSY      = r_busy;
   assign o_GNT_ID    = r_gnt;
   assign o_MUL_START = r_start;
   assign o_MUL_A     = r_mul_a;
   assign o_MUL_B     = r_mul_b;

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module   : tb_mult_share_arbiter
//  Purpose  : Self-checking bench for mult_share_arbiter. A behavioural
//             shift-add multiplier stub answers START; a cycle-level
//             reference model predicts grant order, START/ACK timing,
//             results, BUSY and ERR from the arbitration rules.
//  Revision : 1.0  initial release
//------------------------------------------------------------------------------
module tb_mult_share_arbiter;
   localparam int N_REQ        = 4;
   localparam int W            = 4;
   localparam int BUSY_TIMEOUT = 4;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [N_REQ-1:0]     req;
   logic [N_REQ*W-1:0]   a_bus;
   logic [N_REQ*W-1:0]   b_bus;
   logic [N_REQ-1:0]     o_ack;
   logic [2*W-1:0]       o_result;
   logic                 o_err;
   logic                 o_busy;
   logic [2:0]           o_gnt_id;
   logic                 o_mul_start;
   logic [W-1:0]         o_mul_a;
   logic [W-1:0]         o_mul_b;
   logic                 mul_done = 1'b1;
   logic [2*W-1:0]       mul_prod = '0;
   logic                 stuck;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mult_share_arbiter #(.N_REQ(N_REQ), .W(W), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
      .i_CLK        (clk),
      .i_RESET      (rst_n),
      .i_REQ        (req),
      .i_A          (a_bus),
      .i_B          (b_bus),
      .o_ACK        (o_ack),
      .o_RESULT     (o_result),
      .o_ERR        (o_err),
      .o_BUSY       (o_busy),
      .o_GNT_ID     (o_gnt_id),
      .o_MUL_START  (o_mul_start),
      .o_MUL_A      (o_mul_a),
      .o_MUL_B      (o_mul_b),
      .i_MUL_DONE   (mul_done),
      .i_MUL_PRODUCT(mul_prod)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Multiplier stub: DONE low for 9+popcount(B) cycles after taking START,
   // which gives the 12+popcount(B) grant-to-ACK latency of the real datapath.
   // With 'stuck' set it never leaves idle.
   int   stub_rem = 0;
   logic stub_run = 1'b0;
   always @(posedge clk) begin
      if (stuck) begin
         mul_done <= 1'b1;
         stub_run <= 1'b0;
      end else if (stub_run) begin
         if (stub_rem == 1) begin
            mul_done <= 1'b1;
            stub_run <= 1'b0;
         end
         stub_rem <= stub_rem - 1;
      end else if (o_mul_start) begin
         stub_run <= 1'b1;
         mul_done <= 1'b0;
         stub_rem <= 9 + $countones(o_mul_b);
         mul_prod <= o_mul_a * o_mul_b;
      end
   end

   // Reference model, evaluated each falling edge. 'ne' counts falling
   // edges; START of a grant is expected one falling edge after the IDLE
   // cycle that sees the request, ACK 11+popcount(B) falling edges later.
   int               ne       = 0;
   bit               valid    = 0;
   int               start_ne = -10;
   int               ack_ne   = -10;
   int               free_at  = 0;
   int               m_ptr    = 0;
   int               m_id     = 0;
   logic [W-1:0]     pa, pb;
   logic [2*W-1:0]   pres;
   bit               perr;
   logic [N_REQ-1:0] e_ack;
   logic [2*W-1:0]   e_res  = '0;
   logic             e_err  = 1'b0;
   logic [2:0]       e_gnt  = '0;
   logic [W-1:0]     e_mula = '0;
   logic [W-1:0]     e_mulb = '0;

   always @(negedge clk) begin
      if (valid) begin
         if (ne == start_ne) begin
            e_gnt  = 3'(m_id);
            e_mula = pa;
            e_mulb = pb;
         end
         e_ack = '0;
         if (ne == ack_ne) begin
            e_res = pres;
            if (perr) e_err = 1'b1;
            e_ack[m_id] = 1'b1;
         end
         check_val("ack",    32'(o_ack),       32'(e_ack));
         check_val("result", 32'(o_result),    32'(e_res));
         check_val("err",    32'(o_err),       32'(e_err));
         check_val("busy",   32'(o_busy),      32'(ne >= start_ne && ne <= ack_ne));
         check_val("start",  32'(o_mul_start), 32'(ne == start_ne));
         check_val("gnt_id", 32'(o_gnt_id),    32'(e_gnt));
         check_val("mul_a",  32'(o_mul_a),     32'(e_mula));
         check_val("mul_b",  32'(o_mul_b),     32'(e_mulb));
      end
      // Predict what the next rising edge does.
      if (rst_n !== 1'b1) begin
         valid    = 1;
         start_ne = -10;
         ack_ne   = -10;
         free_at  = ne + 1;
         m_ptr    = 0;
         e_res    = '0;
         e_err    = 1'b0;
         e_gnt    = '0;
         e_mula   = '0;
         e_mulb   = '0;
      end else if (valid) begin
         if (ne == ack_ne) begin
            m_ptr   = (m_id + 1) % N_REQ;
            free_at = ne + 1;
         end else if (ne >= free_at && req != '0 && mul_done) begin
            for (int k = N_REQ - 1; k >= 0; k--)
               if (req[(m_ptr + k) % N_REQ]) m_id = (m_ptr + k) % N_REQ;
            pa       = a_bus[m_id*W +: W];
            pb       = b_bus[m_id*W +: W];
            start_ne = ne + 1;
            if (stuck) begin
               ack_ne = start_ne + BUSY_TIMEOUT + 1;
               pres   = '0;
               perr   = 1;
            end else begin
               ack_ne = start_ne + 11 + $countones(pb);
               pres   = pa * pb;
               perr   = 0;
            end
            free_at = ack_ne + 1;
         end
      end
      ne++;
   end

   task automatic set_req(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
      req[k]          = 1'b1;
      a_bus[k*W +: W] = a;
      b_bus[k*W +: W] = b;
   endtask

   task automatic wait_any_ack(output int id);
      bit got = 0;
      id = -1;
      for (int c = 0; c < 200 && !got; c++) begin
         @(posedge clk); #2;
         if (o_ack != '0) begin
            got = 1;
            for (int k = 0; k < N_REQ; k++) if (o_ack[k]) id = k;
         end
      end
      if (!got) check_val("ack_wait_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_req(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
      int id;
      set_req(k, a, b);
      wait_any_ack(id);
      check_val("ack_owner", 32'(id), 32'(k));
      req[k] = 1'b0;
   endtask

   int             id;
   int             exp_rr[5] = '{0, 1, 2, 3, 0};
   logic [W-1:0]   ra, rb;
   bit             seen;

   initial begin
      rst_n = 1'b0; req = '0; a_bus = '0; b_bus = '0; stuck = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      do_req(0, 4'd5, 4'd3);
      check_val("single_result", 32'(o_result), 32'd15);
      do_req(0, 4'd9, 4'd0);
      check_val("b_zero_result", 32'(o_result), 32'd0);
      do_req(0, 4'd15, 4'd15);
      check_val("max_result", 32'(o_result), 32'd225);

      // Pointer wrap: after requester 3, requester 0 wins over 3.
      do_req(3, 4'd7, 4'd2);
      set_req(0, 4'd3, 4'd4);
      set_req(3, 4'd6, 4'd5);
      wait_any_ack(id); check_val("wrap_first", 32'(id), 32'd0); req[0] = 1'b0;
      wait_any_ack(id); check_val("wrap_second", 32'(id), 32'd3); req[3] = 1'b0;

      // All four held high: strict rotation.
      for (int k = 0; k < N_REQ; k++) set_req(k, 4'(k + 3), 4'(15 - k));
      for (int i = 0; i < 5; i++) begin
         wait_any_ack(id);
         check_val("rr_order", 32'(id), 32'(exp_rr[i]));
         if (i == 4) req = '0;
         else if (id >= 0) set_req(id, 4'($urandom), 4'($urandom));
      end

      // Multiplier never leaves idle.
      @(posedge clk); #2 stuck = 1'b1;
      do_req(1, 4'd11, 4'd13);
      check_val("timeout_err", 32'(o_err), 32'd1);
      check_val("timeout_result", 32'(o_result), 32'd0);
      stuck = 1'b0;
      do_req(2, 4'd3, 4'd3);
      check_val("err_sticky", 32'(o_err), 32'd1);

      // Reset while the multiplier is busy.
      set_req(1, 4'd13, 4'd11);
      seen = 0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(posedge clk); #2;
         if (o_mul_start) seen = 1;
      end
      if (!seen) check_val("start_wait_timeout", 32'd0, 32'd1);
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0; req = '0;
      @(posedge clk); #2;
      check_val("rst_ack", 32'(o_ack), 32'd0);
      check_val("rst_busy", 32'(o_busy), 32'd0);
      check_val("rst_err", 32'(o_err), 32'd0);
      rst_n = 1'b1;
      do_req(2, 4'd6, 4'd7);
      check_val("post_rst_result", 32'(o_result), 32'd42);

      // Random traffic; requests held until ACK, optionally renewed at ACK.
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk); #2;
         for (int k = 0; k < N_REQ; k++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            if (o_ack[k]) begin
               if ($urandom_range(0, 1) == 1) set_req(k, ra, rb);
               else req[k] = 1'b0;
            end else if (!req[k] && $urandom_range(0, 7) == 0) begin
               set_req(k, ra, rb);
            end
         end
      end
      req = '0;
      seen = 0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(posedge clk); #2;
         if (!o_busy) seen = 1;
      end
      if (!seen) check_val("drain_timeout", 32'd0, 32'd1);
      repeat (3) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
